seq_mult_hs: RTL and testbench

//   Parametrised sequential shift-add multiplier: c = a * b, unsigned or two's-complement

---
 rtl/seq_mult_hs.sv | 110 +++++++++++
 tb/tb_seq_mult_hs.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_hs.sv
// seq_mult_hs: sequential shift-add multiplier, c = a * b, unsigned or signed per operation.
//   Ports: clk, rst (async, active-high); operand side start/in_ready with sign_mode, a, b;
//   result side c/c_valid/c_ready; busy high while iterating.
//   One bit of |a| is consumed per cycle, so a result takes A_WIDTH cycles after accept.
module seq_mult_hs #(
    parameter int A_WIDTH = 3,
    parameter int B_WIDTH = 4,
    localparam int P_WIDTH = A_WIDTH + B_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               in_ready,
    input  logic               sign_mode,
    input  logic [A_WIDTH-1:0] a,
    input  logic [B_WIDTH-1:0] b,
    output logic [P_WIDTH-1:0] c,
    output logic               c_valid,
    input  logic               c_ready,
    output logic               busy
);
    localparam int CW = $clog2(A_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_q, state_d;
    logic [A_WIDTH-1:0] a_mag_q, a_mag_d;
    logic [P_WIDTH-1:0] b_mag_q, b_mag_d;
    logic [P_WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic [P_WIDTH-1:0] c_q, c_d;
    logic               c_valid_q, c_valid_d;
    logic               busy_q, busy_d;
    logic               accept;
    logic [A_WIDTH-1:0] a_abs;
    logic [B_WIDTH-1:0] b_abs;

    // Gated by rst so nothing is accepted while reset is held.
    assign in_ready = !rst && (state_q == IDLE || (state_q == DONE && c_ready));
    assign accept   = start && in_ready;
    // The most-negative value negates to itself, which read unsigned is exactly 2^(W-1).
    assign a_abs    = (sign_mode && a[A_WIDTH-1]) ? -a : a;
    assign b_abs    = (sign_mode && b[B_WIDTH-1]) ? -b : b;
    assign c        = c_q;
    assign c_valid  = c_valid_q;
    assign busy     = busy_q;

    always_comb begin
        state_d   = state_q;
        a_mag_d   = a_mag_q;
        b_mag_d   = b_mag_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        c_d       = c_q;
        c_valid_d = c_valid_q;
        busy_d    = busy_q;
        if (state_q == BUSY) begin
            acc_d   = a_mag_q[0] ? acc_q + (b_mag_q << cnt_q) : acc_q;
            a_mag_d = a_mag_q >> 1;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CW'(A_WIDTH - 1)) begin
                state_d   = DONE;
                busy_d    = 1'b0;
                c_valid_d = 1'b1;
                // A zero magnitude negates to zero, so no negative-zero pattern can appear.
                c_d       = neg_q ? -acc_d : acc_d;
            end
        end
        if (state_q == DONE && c_ready) begin
            state_d   = IDLE;
            c_valid_d = 1'b0;
        end
        // Accept wins over the DONE->IDLE move, giving back-to-back operation.
        if (accept) begin
            state_d = BUSY;
            busy_d  = 1'b1;
            a_mag_d = a_abs;
            b_mag_d = P_WIDTH'(b_abs);
            neg_d   = sign_mode && (a[A_WIDTH-1] ^ b[B_WIDTH-1]);
            acc_d   = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            a_mag_q   <= '0;
            b_mag_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            c_q       <= '0;
            c_valid_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_mag_q   <= a_mag_d;
            b_mag_q   <= b_mag_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            c_q       <= c_d;
            c_valid_q <= c_valid_d;
            busy_q    <= busy_d;
        end
    end
endmodule

// File: tb/tb_seq_mult_hs.sv
// tb_seq_mult_hs: scoreboard bench for seq_mult_hs with directed and random operations.
module tb_seq_mult_hs;
    logic       clk = 0;
    logic       rst = 1;
    logic       start = 0;
    logic       in_ready;
    logic       sign_mode = 0;
    logic [2:0] a = 0;
    logic [3:0] b = 0;
    logic [6:0] c;
    logic       c_valid;
    logic       c_ready = 0;
    logic       busy;

    int         checks = 0;
    int         fails = 0;
    logic [6:0] exp_q[$];
    logic       rdy_rand = 0;
    logic       rdy_val = 0;
    logic       hold_v = 0;
    logic [6:0] hold_c = 0;

    seq_mult_hs dut (
        .clk(clk), .rst(rst), .start(start), .in_ready(in_ready), .sign_mode(sign_mode),
        .a(a), .b(b), .c(c), .c_valid(c_valid), .c_ready(c_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] model(input logic sm, input logic [2:0] aa, input logic [3:0] bb);
        int av = sm ? int'($signed(aa)) : int'(aa);
        int bv = sm ? int'($signed(bb)) : int'(bb);
        return 7'(av * bv);
    endfunction

    always @(posedge clk) begin
        #2;
        c_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_val;
    end

    // Monitor: pops on every result handshake and checks results hold while stalled.
    always @(negedge clk) begin
        if (rst) begin
            hold_v = 0;
        end else begin
            if (hold_v) begin
                chk("stall_valid", c_valid, 1);
                chk("stall_c", c, hold_c);
            end
            if (c_valid && c_ready) begin
                if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
                else chk("result", c, exp_q.pop_front());
            end
            hold_v = c_valid && !c_ready;
            hold_c = c;
        end
    end

    task automatic issue(input logic sm, input logic [2:0] aa, input logic [3:0] bb);
        int n = 0;
        @(posedge clk) #1;
        start = 1; sign_mode = sm; a = aa; b = bb;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                chk("accept_timeout", 0, 1);
                start = 0;
                return;
            end
        end
        exp_q.push_back(model(sm, aa, bb));
        @(posedge clk) #1;
        start = 0;
    endtask

    task automatic lat(input logic [6:0] e);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k < 4) begin
                chk("lat_busy", busy, 1);
                chk("lat_not_valid", c_valid, 0);
            end else begin
                chk("lat_valid", c_valid, 1);
                chk("lat_c", c, e);
                chk("lat_busy_off", busy, 0);
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        int n;
        #3;
        chk("rst_c", c, 0);
        chk("rst_valid", c_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        #9 rst = 0;
        #1 chk("rel_in_ready", in_ready, 1);

        rdy_val = 1;
        issue(0, 3'b111, 4'b1111);
        lat(7'd105);
        issue(1, 3'b100, 4'b0111);
        lat(7'b1100100);
        issue(1, 3'b100, 4'b1000);
        lat(7'b0100000);
        issue(1, 3'b011, 4'b0000);
        lat(7'd0);
        issue(1, 3'b000, 4'b1001);
        lat(7'd0);
        drain();

        // Backpressure with ignored start pulses, then back-to-back re-accept.
        rdy_val = 0;
        issue(0, 3'd5, 4'd9);
        n = 0;
        while (!c_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid_seen", c_valid, 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk) #1;
            start = 1; sign_mode = 0; a = 3'd7; b = 4'd15;
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_c", c, 45);
        end
        @(posedge clk) #1;
        a = 3'b010; b = 4'b0011; sign_mode = 0; rdy_val = 1;
        @(negedge clk);
        chk("b2b_in_ready", in_ready, 1);
        exp_q.push_back(model(0, 3'b010, 4'b0011));
        @(posedge clk) #1;
        start = 0;
        lat(7'd6);
        drain();

        // Reset during the second busy cycle.
        issue(0, 3'd7, 4'd7);
        @(posedge clk) #1;
        rst = 1;
        #1;
        chk("mid_rst_valid", c_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_c", c, 0);
        exp_q.delete();
        @(negedge clk);
        rst = 0;
        issue(0, 3'b001, 4'b0010);
        lat(7'd2);
        drain();

        rdy_rand = 1;
        for (int i = 0; i < 150; i++) begin
            issue(1'($urandom), 3'($urandom), 4'($urandom));
            repeat ($urandom_range(0, 4)) @(posedge clk);
        end
        drain();
        repeat (10) @(negedge clk);
        chk("no_extra", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
